multi_servo_pwm: RTL and testbench
==================================

// Module: multi_servo_pwm
// PURPOSE
//  Parametrised N-channel servo PWM generator; successor to the single-channel servo driver.
//  Sits behind the UART command decoder and drives the plate-tilt servo pins.
//  Shares one frame counter across all channels. Adds:
//   - per-channel addressed position writes
//   - clamping
//   - frame-synchronous update (no runt or torn pulses)
//   - per-channel slew limiting and enable gating
//   - a frame-start strobe
// PARAMETERS
//  NUM_CH       2    number of servo channels
//  POS_W        10   width of position command
//  FRAME_TICKS  360  tick_en periods per PWM frame
//  MIN_TICKS    139  pulse width (ticks) at position 0
//  POS_MAX      220  position clamp ceiling; elaboration error unless MIN_TICKS+POS_MAX < FRAME_TICKS
//  RESET_POS    100  target/active position after reset
//  SLEW_STEP    0    max position change per frame; 0 = jump straight to target
// PORTS
//  clk         in   1                 system clock
//  reset       in   1                 synchronous, active-high reset
//  tick_en     in   1                 prescaler enable; frame counter advances only when high
//  pos_wr      in   1                 write strobe, one cycle per command
//  pos_ch      in   $clog2(NUM_CH)+1  channel index for write
//  pos_data    in   POS_W             requested position
//  ch_en       in   NUM_CH            per-channel output enable
//  pwm_out     out  NUM_CH            servo pulse outputs, registered
//  frame_start out  1                 one-cycle strobe at frame boundary
//  wr_err      out  1                 one-cycle strobe: write to pos_ch >= NUM_CH
// BEHAVIOUR
//  Clock and reset
//   - One clock (clk). reset is synchronous and active-high.
//   - On reset: cnt=0; target[]=active[]=RESET_POS; en_lat[]=0; pwm_out=0; frame_start=0; wr_err=0.
//   - Reset mid-frame: pwm_out goes low on the next edge and the frame restarts at cnt=0.
//  Frame counter
//   - CNT_W = $clog2(FRAME_TICKS). cnt counts 0..FRAME_TICKS-1 on tick_en.
//   - Boundary event B = tick_en && cnt==FRAME_TICKS-1. On B, cnt wraps to 0.
//   - frame_start is registered and high for the one cycle after B.
//  Position writes
//   - When pos_wr=1 and pos_ch<NUM_CH: target[pos_ch] <= min(pos_data, POS_MAX) on the same edge.
//   - Takes effect at the next B only; the current frame's pulse is unchanged.
//   - When pos_wr=1 and pos_ch>=NUM_CH: no state change; wr_err=1 on the next cycle.
//   - A write coincident with B is included in that boundary's update (target updated first).
//  Frame-boundary update (on B, per channel)
//   - SLEW_STEP==0: active <= target.
//   - Otherwise: active moves toward target by min(|target-active|, SLEW_STEP).
//   - en_lat <= ch_en.
//   - mark = MIN_TICKS + active, computed at CNT_W+1 bits with no overflow.
//  Output
//   - pwm_out[ch] <= en_lat[ch] && (cnt < mark[ch]), registered: one cycle latency from cnt.
//   - Result: exactly mark tick periods high per frame, starting the cycle after B.
//   - ch_en changes mid-frame never truncate or extend the current pulse.
//   - tick_en low freezes cnt and holds pwm_out steady.
// STRUCTURE
//  Package servo_pwm_pkg:
//   - default frame/pulse constants
//   - CNT_W function
//   - clamp/slew step helper function
//  Sub-module servo_slew_channel, one instance per channel via generate:
//   - holds target, active, en_lat and mark
//   - produces pwm bit from shared cnt and B
//  Top level owns:
//   - frame counter
//   - write decode
//   - wr_err and frame_start
// TESTING (defaults, tick_en=1 unless stated)
//  1. reset 3 cycles then release
//     -> pwm_out=0 during reset;
//     -> first frame: both channels high 0 cycles (en_lat=0);
//     -> ch_en=11 from start: high 239 cycles from 2nd frame.
//  2. Write ch0=50 at cnt=100, ch_en=11
//     -> current frame ch0 still 239 high;
//     -> next frame ch0 189 high; ch1 239 unchanged.
//  3. SLEW_STEP=8, active 100, write target 140
//     -> successive frames 247,255,263,271,279, then constant 279.
//  4. Write pos_data=1023
//     -> clamped to 220, pulse 359 high.
//     Write pos_ch=2
//     -> wr_err pulse one cycle, no channel changes.
//  5. Drop ch_en[1] at cnt=50
//     -> current pulse completes 239 high; next frame ch1 low.
//     tick_en every 4th cycle
//     -> frame_start period 1440 cycles, pulse 956 cycles.
//  6. Assert reset at cnt=120 mid-pulse
//     -> pwm_out low next edge; cnt=0 after release; target and active back to RESET_POS.

Source files
------------

// File: rtl/servo_pwm_pkg.sv
// Shared constants and helpers for the multi-channel servo PWM block.
// Frame geometry defaults plus clamp/slew arithmetic used by every channel.
package servo_pwm_pkg;

    localparam int DEF_NUM_CH      = 2;
    localparam int DEF_POS_W       = 10;
    localparam int DEF_FRAME_TICKS = 360;
    localparam int DEF_MIN_TICKS   = 139;
    localparam int DEF_POS_MAX     = 220;
    localparam int DEF_RESET_POS   = 100;
    localparam int DEF_SLEW_STEP   = 0;

    function automatic int cnt_w(input int frame_ticks);
        return $clog2(frame_ticks);
    endfunction

    function automatic int clamp_pos(input int pos, input int pos_max);
        return (pos > pos_max) ? pos_max : pos;
    endfunction

    // One frame's worth of movement from act toward tgt; step 0 means jump.
    function automatic int slew_next(input int tgt, input int act, input int step);
        if (step == 0) return tgt;
        if (tgt > act) return (tgt - act > step) ? act + step : tgt;
        return (act - tgt > step) ? act - step : tgt;
    endfunction

endpackage

// File: rtl/servo_slew_channel.sv
// One servo channel: pending target, frame-latched position/enable and pulse mark.
// Everything visible on the pin changes only at the frame boundary.
module servo_slew_channel
    import servo_pwm_pkg::*;
#(
    parameter int POS_W     = DEF_POS_W,
    parameter int CNT_W     = 9,
    parameter int MIN_TICKS = DEF_MIN_TICKS,
    parameter int RESET_POS = DEF_RESET_POS,
    parameter int SLEW_STEP = DEF_SLEW_STEP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] cnt,
    input  logic             bnd,
    input  logic             wr,
    input  logic [POS_W-1:0] wr_pos,
    input  logic             ch_en,
    output logic             pwm
);

    logic [POS_W-1:0] target;
    logic [POS_W-1:0] active;
    logic [POS_W-1:0] tgt_nxt;
    logic [POS_W-1:0] act_nxt;
    logic             en_lat;
    logic [CNT_W:0]   mark;

    // A write landing on the boundary edge is already visible to the update.
    always_comb begin
        tgt_nxt = wr ? wr_pos : target;
        act_nxt = POS_W'(slew_next(int'(tgt_nxt), int'(active), SLEW_STEP));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            target <= POS_W'(RESET_POS);
            active <= POS_W'(RESET_POS);
            en_lat <= 1'b0;
            mark   <= (CNT_W+1)'(MIN_TICKS + RESET_POS);
            pwm    <= 1'b0;
        end else begin
            target <= tgt_nxt;
            if (bnd) begin
                active <= act_nxt;
                en_lat <= ch_en;
                mark   <= (CNT_W+1)'(MIN_TICKS + int'(act_nxt));
            end
            pwm <= en_lat && ({1'b0, cnt} < mark);
        end
    end

endmodule

// File: rtl/multi_servo_pwm.sv
// N-channel servo PWM generator sharing a single frame counter.
// Owns the counter, write decode and the frame_start / wr_err strobes.
module multi_servo_pwm
    import servo_pwm_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int POS_W       = DEF_POS_W,
    parameter int FRAME_TICKS = DEF_FRAME_TICKS,
    parameter int MIN_TICKS   = DEF_MIN_TICKS,
    parameter int POS_MAX     = DEF_POS_MAX,
    parameter int RESET_POS   = DEF_RESET_POS,
    parameter int SLEW_STEP   = DEF_SLEW_STEP
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick_en,
    input  logic                    pos_wr,
    input  logic [$clog2(NUM_CH):0] pos_ch,
    input  logic [POS_W-1:0]        pos_data,
    input  logic [NUM_CH-1:0]       ch_en,
    output logic [NUM_CH-1:0]       pwm_out,
    output logic                    frame_start,
    output logic                    wr_err
);

    localparam int CNT_W = cnt_w(FRAME_TICKS);
    localparam int CH_W  = $clog2(NUM_CH) + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_TICKS - 1);
    localparam logic [CH_W-1:0]  CH_LIM   = CH_W'(NUM_CH);

    if (MIN_TICKS + POS_MAX >= FRAME_TICKS) begin : g_bad_cfg
        $error("multi_servo_pwm: MIN_TICKS + POS_MAX must be below FRAME_TICKS");
    end

    logic [CNT_W-1:0] cnt;
    logic             bnd;
    logic             ch_ok;
    logic [POS_W-1:0] wr_pos;

    always_comb begin
        bnd    = tick_en && (cnt == CNT_LAST);
        ch_ok  = pos_ch < CH_LIM;
        wr_pos = POS_W'(clamp_pos(int'(pos_data), POS_MAX));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            frame_start <= 1'b0;
            wr_err      <= 1'b0;
        end else begin
            if (tick_en) cnt <= bnd ? '0 : cnt + 1'b1;
            frame_start <= bnd;
            wr_err      <= pos_wr && !ch_ok;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        servo_slew_channel #(
            .POS_W     (POS_W),
            .CNT_W     (CNT_W),
            .MIN_TICKS (MIN_TICKS),
            .RESET_POS (RESET_POS),
            .SLEW_STEP (SLEW_STEP)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .cnt    (cnt),
            .bnd    (bnd),
            .wr     (pos_wr && ch_ok && (pos_ch == CH_W'(i))),
            .wr_pos (wr_pos),
            .ch_en  (ch_en[i]),
            .pwm    (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_multi_servo_pwm.sv
// Bench for multi_servo_pwm: jump and slew instances against a frame-level model.
// Directed scenarios pin pulse widths; a random phase follows.
module tb_multi_servo_pwm;

    localparam int NCH  = 2;
    localparam int FT   = 360;
    localparam int MIN  = 139;
    localparam int PMAX = 220;
    localparam int RP   = 100;
    localparam int SL   = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_en;
    logic       pos_wr;
    logic [1:0] pos_ch;
    logic [9:0] pos_data;
    logic [1:0] ch_en;
    logic [1:0] pwm0, pwm1;
    logic       fs0, fs1, err0, err1;

    always #5 clk = ~clk;

    multi_servo_pwm dut0 (
        .clk(clk), .reset(reset), .tick_en(tick_en), .pos_wr(pos_wr),
        .pos_ch(pos_ch), .pos_data(pos_data), .ch_en(ch_en),
        .pwm_out(pwm0), .frame_start(fs0), .wr_err(err0)
    );

    multi_servo_pwm #(.SLEW_STEP(SL)) dut1 (
        .clk(clk), .reset(reset), .tick_en(tick_en), .pos_wr(pos_wr),
        .pos_ch(pos_ch), .pos_data(pos_data), .ch_en(ch_en),
        .pwm_out(pwm1), .frame_start(fs1), .wr_err(err1)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Model: position within frame, pending targets, per-instance frame positions.
    int  m_cnt;
    int  m_tgt [NCH];
    int  m_act [2][NCH];
    bit  m_en  [NCH];
    bit  m_pwm [2][NCH];
    bit  m_fs, m_err, m_valid = 0, m_rst;

    function automatic int slew(input int tgt, input int act, input int s);
        int d;
        d = tgt - act;
        if (s == 0) return tgt;
        if (d > s) d = s;
        if (d < -s) d = -s;
        return act + d;
    endfunction

    always @(posedge clk) begin
        bit b;
        m_rst = reset;
        if (reset) begin
            m_cnt = 0; m_fs = 0; m_err = 0; m_valid = 1;
            for (int c = 0; c < NCH; c++) begin
                m_tgt[c] = RP; m_en[c] = 0;
                m_act[0][c] = RP; m_act[1][c] = RP;
                m_pwm[0][c] = 0; m_pwm[1][c] = 0;
            end
        end else begin
            b = tick_en && (m_cnt == FT - 1);
            for (int d = 0; d < 2; d++)
                for (int c = 0; c < NCH; c++)
                    m_pwm[d][c] = m_en[c] && (m_cnt < MIN + m_act[d][c]);
            m_err = pos_wr && (int'(pos_ch) >= NCH);
            if (pos_wr && int'(pos_ch) < NCH)
                m_tgt[pos_ch] = (int'(pos_data) > PMAX) ? PMAX : int'(pos_data);
            m_fs = b;
            if (b)
                for (int c = 0; c < NCH; c++) begin
                    m_act[0][c] = slew(m_tgt[c], m_act[0][c], 0);
                    m_act[1][c] = slew(m_tgt[c], m_act[1][c], SL);
                    m_en[c] = ch_en[c];
                end
            if (tick_en) m_cnt = b ? 0 : m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            for (int c = 0; c < NCH; c++) begin
                chk($sformatf("pwm0[%0d]", c), 32'(pwm0[c]), 32'(m_pwm[0][c]));
                chk($sformatf("pwm1[%0d]", c), 32'(pwm1[c]), 32'(m_pwm[1][c]));
            end
            chk("frame_start0", 32'(fs0), 32'(m_fs));
            chk("frame_start1", 32'(fs1), 32'(m_fs));
            chk("wr_err0", 32'(err0), 32'(m_err));
            chk("wr_err1", 32'(err1), 32'(m_err));
        end
    end

    // Per-frame measurement of DUT pulse widths and frame period.
    int hi [2][NCH];
    int w  [2][NCH];
    int since, period;

    always @(negedge clk) begin
        if (m_rst) begin
            since = 0;
            for (int c = 0; c < NCH; c++) begin hi[0][c] = 0; hi[1][c] = 0; end
        end else begin
            since++;
            for (int c = 0; c < NCH; c++) begin
                hi[0][c] += int'(pwm0[c]);
                hi[1][c] += int'(pwm1[c]);
            end
            if (m_fs) begin
                period = since; since = 0;
                for (int c = 0; c < NCH; c++) begin
                    w[0][c] = hi[0][c]; w[1][c] = hi[1][c];
                    hi[0][c] = 0; hi[1][c] = 0;
                end
            end
        end
    end

    bit sparse = 0;
    int tph = 0;

    task automatic cyc();
        @(negedge clk);
        pos_wr = 0;
        tick_en = sparse ? (tph % 4 == 3) : 1'b1;
        tph++;
    endtask

    task automatic wr(input int ch, input int data);
        pos_wr = 1; pos_ch = 2'(ch); pos_data = 10'(data);
        cyc();
    endtask

    task automatic wait_fs();
        bit ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            cyc();
            if (m_fs) ok = 1;
        end
        #1;
        if (!ok) chk("frame_timeout", 0, 1);
    endtask

    task automatic wait_cnt(input int v);
        bit ok = 0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            cyc();
            if (m_cnt == v) ok = 1;
        end
        if (!ok) chk("cnt_timeout", 0, 1);
    endtask

    task automatic do_reset();
        reset = 1;
        repeat (3) begin
            cyc();
            chk("rst_pwm0", 32'(pwm0), 0);
            chk("rst_pwm1", 32'(pwm1), 0);
        end
        reset = 0;
    endtask

    int sl_exp [6] = '{247, 255, 263, 271, 279, 279};
    int n;

    initial begin
        reset = 1; tick_en = 1; pos_wr = 0; pos_ch = 0; pos_data = 0; ch_en = 2'b11;

        // Reset, first frame dark, second frame at reset position.
        do_reset();
        wait_fs();
        chk("f1_ch0", w[0][0], 0);
        chk("f1_ch1", w[0][1], 0);
        wait_fs();
        chk("f2_ch0", w[0][0], 239);
        chk("f2_ch1", w[0][1], 239);

        // Mid-frame write lands only at the next boundary.
        wait_cnt(100);
        wr(0, 50);
        wait_fs();
        chk("wr_cur_ch0", w[0][0], 239);
        wait_fs();
        chk("wr_nxt_ch0", w[0][0], 189);
        chk("wr_nxt_ch1", w[0][1], 239);
        chk("wr_slew_ch0", w[1][0], 231);

        // Slew toward 140 in steps of 8.
        do_reset();
        wr(0, 140);
        wait_fs();
        chk("slew_f1", w[1][0], 0);
        for (int k = 0; k < 6; k++) begin
            wait_fs();
            chk($sformatf("slew_f%0d", k + 2), w[1][0], sl_exp[k]);
            if (k == 0) chk("jump_ch0", w[0][0], 279);
        end

        // Clamp and bad-channel write.
        wr(1, 1023);
        wait_fs();
        wait_fs();
        chk("clamp_ch1", w[0][1], 359);
        wr(2, 5);
        chk("wr_err_hi", 32'(err0), 1);
        cyc();
        chk("wr_err_lo", 32'(err0), 0);
        wr(3, 0);
        wait_fs();
        wait_fs();
        chk("bad_wr_ch0", w[0][0], 279);
        chk("bad_wr_ch1", w[0][1], 359);

        // Enable drop mid-pulse, then a sparse tick_en.
        do_reset();
        wait_fs();
        wait_fs();
        wait_cnt(50);
        ch_en = 2'b01;
        wait_fs();
        chk("en_cur_ch1", w[0][1], 239);
        wait_fs();
        chk("en_off_ch1", w[0][1], 0);
        sparse = 1; tph = 0;
        wait_fs();
        wait_fs();
        chk("sparse_period", period, 1440);
        chk("sparse_pulse", w[0][0], 956);
        sparse = 0;

        // Reset mid-pulse discards a pending write.
        ch_en = 2'b11;
        wait_fs();
        wait_cnt(10);
        wr(0, 30);
        wait_cnt(120);
        chk("pre_rst_hi", 32'(pwm0[0]), 1);
        reset = 1;
        cyc();
        chk("rst_mid_pwm", 32'(pwm0), 0);
        reset = 0;
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            cyc();
            n++;
            if (m_fs) break;
        end
        chk("rst_frame_len", n, 360);
        wait_fs();
        chk("rst_pos_ch0", w[0][0], 239);
        chk("rst_pos_ch1", w[0][1], 239);

        // Random traffic against the model.
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 2999) == 0);
            tick_en = ($urandom_range(0, 9) != 0);
            pos_wr = ($urandom_range(0, 7) == 0);
            pos_ch = 2'($urandom_range(0, 3));
            pos_data = ($urandom_range(0, 3) == 0) ? 10'($urandom)
                                                   : 10'($urandom_range(0, PMAX));
            if ($urandom_range(0, 199) == 0) ch_en = 2'($urandom);
        end
        @(negedge clk);
        reset = 0; pos_wr = 0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
